jala_sequencer: RTL

//  Multi-cycle control FSM for the Jala core. Fetches each instruction over a req/ack

---
 rtl/jala_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/jala_sequencer.sv
// jala_sequencer: multi-cycle control FSM for the Jala core.
// Fetches each instruction over a req/ack handshake, latches it in the IR,
// steps DECODE/EXECUTE/WRITEBACK, strobes the register-file write enable and
// advances the PC.
//
// Optional feature macro: SEQ_ILLEGAL_HALT_EN
//   defined   : unsupported opcodes seen in DECODE send the FSM to HALT
//   undefined : unsupported opcodes retire as NOPs; halted is tied 0
//
// Ports:
//   clk, reset        core clock, synchronous active-high reset
//   imem_req/addr     fetch request and address (addr = pc)
//   imem_ack/rdata    memory accept and fetched word (used in FETCH only)
//   ir                instruction register, feeds the decoder
//   dec_write_en      decoder write enable for the current ir
//   stall             holds the FSM while in EXECUTE
//   rf_write_en       register-file write strobe (WRITEBACK only)
//   pc                address of the instruction in ir
//   retired           retired-instruction counter
//   halted            core halted (illegal-opcode halt build only)
//   state             FSM state code, for debug
module jala_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic        dec_write_en,
  input  logic        stall,
  output logic        rf_write_en,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StWriteback = 3'd3,
    StHalt      = 3'd4
  } state_e;

  localparam logic [31:0] NopInst = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;

`ifdef SEQ_ILLEGAL_HALT_EN
  logic op_legal;
  always_comb begin
    op_legal = (ir_q[6:0] == 7'b0110111) || (ir_q[6:0] == 7'b0010011) ||
               (ir_q[6:0] == 7'b0110011);
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:     if (imem_ack) state_d = StDecode;
`ifdef SEQ_ILLEGAL_HALT_EN
      StDecode:    state_d = op_legal ? StExecute : StHalt;
`else
      StDecode:    state_d = StExecute;
`endif
      StExecute:   if (!stall) state_d = StWriteback;
      StWriteback: state_d = StFetch;
`ifdef SEQ_ILLEGAL_HALT_EN
      StHalt:      state_d = StHalt;
`else
      StHalt:      state_d = StFetch;
`endif
      // Unused codes 5-7 recover to FETCH without touching pc/retired
      default:     state_d = StFetch;
    endcase
  end

  // Datapath next-state: IR loads only on a FETCH handshake, pc/retired only in WRITEBACK
  always_comb begin
    ir_d      = ir_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    if ((state_q == StFetch) && imem_ack) begin
      ir_d = imem_rdata;
    end
    if (state_q == StWriteback) begin
      pc_d      = pc_q + PC_STEP;
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      ir_q      <= NopInst;
      retired_q <= 32'd0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  // Outputs
  always_comb begin
    imem_req    = (state_q == StFetch);
    imem_addr   = pc_q;
    rf_write_en = (state_q == StWriteback) && dec_write_en;
`ifdef SEQ_ILLEGAL_HALT_EN
    halted      = (state_q == StHalt);
`else
    halted      = 1'b0;
`endif
    ir          = ir_q;
    pc          = pc_q;
    retired     = retired_q;
    state       = state_q;
  end

endmodule
